// File: rtl/nanotile_scheduler_if.sv
// Bundle of the job, pixel-shader and tile-flusher signals around the nano-tile scheduler.
// master = scheduler side, slave = the surrounding setup / shader / flusher side.
interface nanotile_scheduler_if;
  logic        job_valid;
  logic        job_ready;
  logic [39:0] job_box;
  logic        job_clear;
  logic        job_done;
  logic [9:0]  tileOffsetX;
  logic [9:0]  tileOffsetY;
  logic [9:0]  start_x;
  logic [9:0]  start_y;
  logic        rasterTileID;
  logic        clearZ;
  logic        startRasterizing;
  logic        doneRasterizing;
  logic        flush_valid;
  logic        flush_ready;
  logic        flush_id;
  logic [9:0]  flush_x;
  logic [9:0]  flush_y;
  logic        flush_done;
  logic        flush_done_id;

  // Handshakes: job and flush transfers complete on a cycle where valid && ready
  // are both high; valid holds its payload stable until then. The shader start
  // is a level: startRasterizing rises, the shader drops doneRasterizing to
  // accept, raises it when finished, and startRasterizing then falls.
  modport master (
    input  job_valid, job_box, job_clear, doneRasterizing,
           flush_ready, flush_done, flush_done_id,
    output job_ready, job_done, tileOffsetX, tileOffsetY, start_x, start_y,
           rasterTileID, clearZ, startRasterizing, flush_valid, flush_id,
           flush_x, flush_y
  );

  modport slave (
    output job_valid, job_box, job_clear, doneRasterizing,
           flush_ready, flush_done, flush_done_id,
    input  job_ready, job_done, tileOffsetX, tileOffsetY, start_x, start_y,
           rasterTileID, clearZ, startRasterizing, flush_valid, flush_id,
           flush_x, flush_y
  );
endinterface

// File: rtl/nanotile_scheduler.sv
// Walks every nano-tile touched by a job's bounding box, drives the pixel shader
// passes and ping-pongs the two shader buffers into the downstream tile flusher.
module nanotile_scheduler #(
  parameter int NANO_DIM = 8,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                 BOARD_CLK,
  input  logic                 RESET_N,
  nanotile_scheduler_if.master bus,
  output logic [2:0]           dbg_state,
  output logic [1:0]           dbg_busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BUF = 3'd1,
    ISSUE    = 3'd2,
    RUN      = 3'd3,
    RELEASE  = 3'd4,
    FLUSH    = 3'd5,
    NEXT     = 3'd6,
    FINISH   = 3'd7
  } state_t;

  localparam logic [10:0] STEP  = 11'(NANO_DIM);
  localparam logic [10:0] MASK  = ~(11'(NANO_DIM - 1));
  localparam logic [10:0] LIM_X = 11'(SCREEN_W);
  localparam logic [10:0] LIM_Y = 11'(SCREEN_H);

  state_t      state, state_n;
  logic [10:0] box_x0, box_y0, box_x1, box_y1, clamp_x1, clamp_y1;
  logic        box_empty, accept, buf_free, fire, row_more, more;
  logic [10:0] tx, ty, tx0, x1_r, y1_r, next_tx, next_ty;
  logic        clear_r, cur;
  logic [1:0]  busy, busy_set, busy_clr;
  logic [9:0]  off_x, off_y, fl_x, fl_y;
  logic        tile_id, clear_z, fl_id;

  // Coordinates are widened to 11 bits so stepping past 1023 cannot wrap.
  assign box_x0   = {1'b0, bus.job_box[39:30]};
  assign box_y0   = {1'b0, bus.job_box[29:20]};
  assign box_x1   = {1'b0, bus.job_box[19:10]};
  assign box_y1   = {1'b0, bus.job_box[9:0]};
  assign clamp_x1 = (box_x1 > LIM_X) ? LIM_X : box_x1;
  assign clamp_y1 = (box_y1 > LIM_Y) ? LIM_Y : box_y1;
  assign box_empty = (clamp_x1 <= box_x0) || (clamp_y1 <= box_y0) ||
                     (box_x0 >= LIM_X) || (box_y0 >= LIM_Y);

  assign accept   = bus.job_valid && (state == IDLE);
  // A release arriving in the same cycle frees the buffer immediately.
  assign buf_free = !busy[cur] || (bus.flush_done && (bus.flush_done_id == cur));
  assign fire     = (state == FLUSH) && bus.flush_ready;
  assign next_tx  = tx + STEP;
  assign next_ty  = ty + STEP;
  assign row_more = next_tx < x1_r;
  assign more     = row_more || (next_ty < y1_r);

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (accept) state_n = box_empty ? FINISH : WAIT_BUF;
      WAIT_BUF: if (buf_free) state_n = ISSUE;
      ISSUE:    if (!bus.doneRasterizing) state_n = RUN;
      RUN:      if (bus.doneRasterizing) state_n = RELEASE;
      RELEASE:  state_n = clear_z ? ISSUE : FLUSH;
      FLUSH:    if (bus.flush_ready) state_n = NEXT;
      NEXT:     state_n = more ? WAIT_BUF : FINISH;
      FINISH:   state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx      <= '0;
      ty      <= '0;
      tx0     <= '0;
      x1_r    <= '0;
      y1_r    <= '0;
      clear_r <= 1'b0;
      cur     <= 1'b0;
      off_x   <= '0;
      off_y   <= '0;
      tile_id <= 1'b0;
      clear_z <= 1'b0;
      fl_id   <= 1'b0;
      fl_x    <= '0;
      fl_y    <= '0;
    end else begin
      if (accept) begin
        tx      <= box_x0 & MASK;
        ty      <= box_y0 & MASK;
        tx0     <= box_x0 & MASK;
        x1_r    <= clamp_x1;
        y1_r    <= clamp_y1;
        clear_r <= bus.job_clear;
      end
      if ((state == WAIT_BUF) && buf_free) begin
        off_x   <= tx[9:0];
        off_y   <= ty[9:0];
        tile_id <= cur;
        clear_z <= clear_r;
      end
      if (state == RELEASE) begin
        if (clear_z) begin
          clear_z <= 1'b0;
        end else begin
          fl_id <= cur;
          fl_x  <= tx[9:0];
          fl_y  <= ty[9:0];
        end
      end
      if (fire) cur <= ~cur;
      if ((state == NEXT) && more) begin
        if (row_more) begin
          tx <= next_tx;
        end else begin
          tx <= tx0;
          ty <= next_ty;
        end
      end
    end
  end

  // Marking a buffer busy takes priority over a simultaneous release of it.
  assign busy_set = fire ? (cur ? 2'b10 : 2'b01) : 2'b00;
  assign busy_clr = bus.flush_done ? (bus.flush_done_id ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) busy <= 2'b00;
    else          busy <= (busy & ~busy_clr) | busy_set;
  end

  a_no_release_on_handoff: assert property (
    @(posedge BOARD_CLK) disable iff (!RESET_N)
      !(fire && bus.flush_done && (bus.flush_done_id == cur))
  );

  assign bus.job_ready        = (state == IDLE);
  assign bus.job_done         = (state == FINISH);
  assign bus.startRasterizing = (state == ISSUE) || (state == RUN);
  assign bus.flush_valid      = (state == FLUSH);
  assign bus.tileOffsetX      = off_x;
  assign bus.tileOffsetY      = off_y;
  assign bus.start_x          = '0;
  assign bus.start_y          = '0;
  assign bus.rasterTileID     = tile_id;
  assign bus.clearZ           = clear_z;
  assign bus.flush_id         = fl_id;
  assign bus.flush_x          = fl_x;
  assign bus.flush_y          = fl_y;
  assign dbg_state            = state;
  assign dbg_busy             = busy;

endmodule

// File: tb/tb_nanotile_scheduler.sv
// Bench for nanotile_scheduler: shader and flusher models, a tile-list model of
// the job traversal, and a negedge compare process against expected queues.
module tb_nanotile_scheduler;
  localparam int D = 8;
  localparam int W = 640;
  localparam int H = 480;
  localparam logic [2:0] S_WAIT_BUF = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd3;

  // ---------------- clock / reset ----------------
  logic BOARD_CLK = 1'b0;
  logic RESET_N   = 1'b0;
  always #5 BOARD_CLK = ~BOARD_CLK;

  nanotile_scheduler_if bus();
  logic [2:0] dbg_state;
  logic [1:0] dbg_busy;

  nanotile_scheduler #(.NANO_DIM(D), .SCREEN_W(W), .SCREEN_H(H)) dut (
    .BOARD_CLK (BOARD_CLK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_busy  (dbg_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- shader model ----------------
  int   sh_n = 20;
  int   sh_cnt;
  logic sh_done;
  always @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sh_done <= 1'b0;
      sh_cnt  <= 0;
    end else if (!bus.startRasterizing) begin
      sh_done <= 1'b0;
      sh_cnt  <= 0;
    end else if (!sh_done) begin
      if (sh_cnt >= sh_n - 1) sh_done <= 1'b1;
      sh_cnt <= sh_cnt + 1;
    end
  end
  assign bus.doneRasterizing = sh_done;

  // ---------------- flusher model ----------------
  int   fr_delay = 0;
  bit   withhold = 1'b0;
  int   fl_wait;
  int   dn_cnt;
  logic fl_ready, a_done, a_id, dn_id;
  logic man_done = 1'b0;
  logic man_id   = 1'b0;
  always @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fl_ready <= 1'b0;
      fl_wait  <= 0;
      a_done   <= 1'b0;
      a_id     <= 1'b0;
      dn_cnt   <= 0;
      dn_id    <= 1'b0;
    end else begin
      a_done <= 1'b0;
      if (dn_cnt == 1) begin
        a_done <= 1'b1;
        a_id   <= dn_id;
      end
      if (dn_cnt > 0) dn_cnt <= dn_cnt - 1;
      if (bus.flush_valid && fl_ready) begin
        fl_ready <= 1'b0;
        fl_wait  <= fr_delay;
        if (!withhold) begin
          dn_cnt <= 2;
          dn_id  <= bus.flush_id;
        end
      end else if (bus.flush_valid) begin
        if (fl_wait <= 0) fl_ready <= 1'b1;
        else              fl_wait  <= fl_wait - 1;
      end
    end
  end
  assign bus.flush_ready   = fl_ready;
  assign bus.flush_done    = a_done | man_done;
  assign bus.flush_done_id = man_done ? man_id : a_id;

  // ---------------- traversal model + scoreboard ----------------
  logic [21:0] exp_pass_q[$];   // {id, x, y, clearZ}
  logic [20:0] exp_flush_q[$];  // {id, x, y}
  int m_cur = 0;

  task automatic model_job(input int x0, input int y0, input int x1, input int y1, input bit clr);
    int xe, ye;
    xe = (x1 > W) ? W : x1;
    ye = (y1 > H) ? H : y1;
    if (x0 >= W || y0 >= H || xe <= x0 || ye <= y0) return;
    for (int ty = (y0 / D) * D; ty < ye; ty += D) begin
      for (int tx = (x0 / D) * D; tx < xe; tx += D) begin
        if (clr) exp_pass_q.push_back({m_cur[0], tx[9:0], ty[9:0], 1'b1});
        exp_pass_q.push_back({m_cur[0], tx[9:0], ty[9:0], 1'b0});
        exp_flush_q.push_back({m_cur[0], tx[9:0], ty[9:0]});
        m_cur ^= 1;
      end
    end
  endtask

  int pass_cnt = 0;
  int fl_hs_cnt = 0;
  int jd_cnt = 0;
  logic        prev_start = 1'b0;
  logic        prev_fv = 1'b0;
  logic [21:0] cur_pass, obs_pass;
  logic [20:0] prev_fl, obs_fl;

  initial begin
    forever begin
      @(negedge BOARD_CLK);
      if (!RESET_N) begin
        prev_start = 1'b0;
        prev_fv    = 1'b0;
      end else begin
        obs_pass = {bus.rasterTileID, bus.tileOffsetX, bus.tileOffsetY, bus.clearZ};
        obs_fl   = {bus.flush_id, bus.flush_x, bus.flush_y};
        chk("start_xy_zero", {bus.start_x, bus.start_y}, 0);
        if (bus.startRasterizing && !prev_start) begin
          pass_cnt++;
          chk("pass_expected", exp_pass_q.size() != 0, 1);
          if (exp_pass_q.size() != 0) begin
            cur_pass = exp_pass_q.pop_front();
            chk("pass_tile", obs_pass, cur_pass);
          end
        end else if (bus.startRasterizing) begin
          chk("pass_stable", obs_pass, cur_pass);
        end
        if (bus.flush_valid && prev_fv) chk("flush_stable", obs_fl, prev_fl);
        if (bus.flush_valid && bus.flush_ready) begin
          fl_hs_cnt++;
          chk("flush_expected", exp_flush_q.size() != 0, 1);
          if (exp_flush_q.size() != 0) chk("flush_tile", obs_fl, exp_flush_q.pop_front());
        end
        if (bus.job_done) jd_cnt++;
        prev_start = bus.startRasterizing;
        prev_fv    = bus.flush_valid && !bus.flush_ready;
        prev_fl    = obs_fl;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge BOARD_CLK);
  endtask

  task automatic submit(input int x0, input int y0, input int x1, input int y1, input bit clr);
    int n;
    @(negedge BOARD_CLK);
    bus.job_box   = {10'(x0), 10'(y0), 10'(x1), 10'(y1)};
    bus.job_clear = clr;
    bus.job_valid = 1'b1;
    n = 0;
    while (!bus.job_ready && n < 200) begin
      @(negedge BOARD_CLK);
      n++;
    end
    chk("job_accept_timeout", n < 200, 1);
    @(negedge BOARD_CLK);
    bus.job_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag, input int d0, input int budget);
    int n;
    n = 0;
    while (jd_cnt == d0 && n < budget) begin
      @(negedge BOARD_CLK);
      n++;
    end
    chk({tag, "_done_timeout"}, n < budget, 1);
    wait_neg(3);
    chk({tag, "_done_once"}, jd_cnt - d0, 1);
    chk({tag, "_pass_q_empty"}, exp_pass_q.size(), 0);
    chk({tag, "_flush_q_empty"}, exp_flush_q.size(), 0);
    chk({tag, "_ready_again"}, bus.job_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_job_ready"}, bus.job_ready, 1);
    chk({tag, "_job_done"}, bus.job_done, 0);
    chk({tag, "_start"}, bus.startRasterizing, 0);
    chk({tag, "_clearZ"}, bus.clearZ, 0);
    chk({tag, "_tile_id"}, bus.rasterTileID, 0);
    chk({tag, "_offset"}, {bus.tileOffsetX, bus.tileOffsetY}, 0);
    chk({tag, "_flush_valid"}, bus.flush_valid, 0);
    chk({tag, "_flush_pay"}, {bus.flush_id, bus.flush_x, bus.flush_y}, 0);
    chk({tag, "_busy"}, dbg_busy, 0);
  endtask

  task automatic do_reset();
    @(negedge BOARD_CLK);
    RESET_N = 1'b0;
    exp_pass_q.delete();
    exp_flush_q.delete();
    m_cur = 0;
    wait_neg(2);
    RESET_N = 1'b1;
    wait_neg(2);
  endtask

  // ---------------- main sequence ----------------
  int d0, p0, f0, n;
  initial begin
    bus.job_valid = 1'b0;
    bus.job_box   = '0;
    bus.job_clear = 1'b0;
    wait_neg(2);
    check_reset_outputs("rst");
    @(negedge BOARD_CLK);
    RESET_N = 1'b1;
    wait_neg(2);

    // Multi-row box with clear passes; buffers alternate from 0.
    fr_delay = 2; sh_n = 6;
    model_job(5, 3, 20, 10, 1'b1);
    chk("A_npass", exp_pass_q.size(), 12);
    chk("A_first", exp_pass_q[0], {1'b0, 10'd0, 10'd0, 1'b1});
    chk("A_p3", exp_pass_q[3], {1'b1, 10'd8, 10'd0, 1'b0});
    chk("A_last", exp_pass_q[11], {1'b1, 10'd16, 10'd8, 1'b0});
    chk("A_fl3", exp_flush_q[3], {1'b1, 10'd0, 10'd8});
    d0 = jd_cnt;
    submit(5, 3, 20, 10, 1'b1);
    finish_job("A", d0, 3000);

    // Single tile, one raster pass, long shader.
    fr_delay = 0; sh_n = 20;
    model_job(0, 0, 8, 8, 1'b0);
    chk("B_npass", exp_pass_q.size(), 1);
    chk("B_first", exp_pass_q[0], {1'b0, 10'd0, 10'd0, 1'b0});
    chk("B_flush", exp_flush_q[0], {1'b0, 10'd0, 10'd0});
    d0 = jd_cnt;
    submit(0, 0, 8, 8, 1'b0);
    finish_job("B", d0, 1000);

    // Box hanging off the bottom-right corner gets clamped.
    sh_n = 5;
    model_job(630, 470, 700, 500, 1'b0);
    chk("C_npass", exp_pass_q.size(), 4);
    chk("C_first", exp_pass_q[0], {1'b1, 10'd624, 10'd464, 1'b0});
    chk("C_fl_last", exp_flush_q[3], {1'b0, 10'd632, 10'd472});
    d0 = jd_cnt;
    submit(630, 470, 700, 500, 1'b0);
    finish_job("C", d0, 1000);

    // Empty box: done the cycle after accept, shader untouched.
    model_job(10, 10, 10, 40, 1'b0);
    chk("D_npass", exp_pass_q.size(), 0);
    d0 = jd_cnt; p0 = pass_cnt;
    submit(10, 10, 10, 40, 1'b0);
    chk("D_done_next", bus.job_done, 1);
    chk("D_start", bus.startRasterizing, 0);
    wait_neg(3);
    chk("D_done_once", jd_cnt - d0, 1);
    chk("D_no_pass", pass_cnt - p0, 0);
    chk("D_ready", bus.job_ready, 1);

    // Reset during the second tile's RUN, then a fresh job from buffer 0.
    sh_n = 10;
    model_job(0, 0, 24, 8, 1'b0);
    d0 = jd_cnt; p0 = pass_cnt;
    submit(0, 0, 24, 8, 1'b0);
    n = 0;
    while (!(pass_cnt == p0 + 2 && dbg_state == S_RUN) && n < 500) begin
      @(negedge BOARD_CLK);
      n++;
    end
    chk("F_reach_run", n < 500, 1);
    #2 RESET_N = 1'b0;
    #1 check_reset_outputs("F_async");
    exp_pass_q.delete();
    exp_flush_q.delete();
    m_cur = 0;
    d0 = jd_cnt;
    wait_neg(2);
    RESET_N = 1'b1;
    wait_neg(2);
    chk("F_no_done", jd_cnt - d0, 0);
    model_job(0, 0, 8, 8, 1'b0);
    chk("F_restart_id0", exp_pass_q[0], {1'b0, 10'd0, 10'd0, 1'b0});
    d0 = jd_cnt;
    submit(0, 0, 8, 8, 1'b0);
    finish_job("F", d0, 1000);

    // Withheld releases: third tile stalls on buffer 0 until flush_done_id=0.
    do_reset();
    withhold = 1'b1; sh_n = 4;
    model_job(0, 0, 24, 8, 1'b0);
    d0 = jd_cnt; f0 = fl_hs_cnt;
    submit(0, 0, 24, 8, 1'b0);
    n = 0;
    while (!(fl_hs_cnt == f0 + 2 && dbg_state == S_WAIT_BUF) && n < 500) begin
      @(negedge BOARD_CLK);
      n++;
    end
    chk("E_reach_stall", n < 500, 1);
    repeat (8) begin
      @(negedge BOARD_CLK);
      chk("E_stall_start", bus.startRasterizing, 0);
      chk("E_stall_busy", dbg_busy, 2'b11);
    end
    man_id = 1'b0; man_done = 1'b1;
    @(negedge BOARD_CLK);
    man_done = 1'b0;
    chk("E_release_start", bus.startRasterizing, 1);
    chk("E_release_busy", dbg_busy, 2'b10);
    finish_job("E", d0, 1000);
    chk("E_end_busy", dbg_busy, 2'b11);
    man_id = 1'b1; man_done = 1'b1;
    @(negedge BOARD_CLK);
    man_id = 1'b0;
    @(negedge BOARD_CLK);
    man_done = 1'b0;
    @(negedge BOARD_CLK);
    chk("E_all_free", dbg_busy, 2'b00);
    withhold = 1'b0;

    wait_neg(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
